// File: rtl/warp_mem_responder_if.sv
// Request/response bus between the Warp engine and its memory responder.
// The engine side is master; the memory side is slave.
interface warp_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_write;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_data,
        output mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_data,
        input  mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/warp_mem_responder.sv
// Word-addressed SRAM responder: posted writes, fixed-latency in-order
// reads through a credit-limited response queue, plus backdoor preload.
module warp_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    warp_mem_responder_if.slave            mem,
    input  logic                           init_we,
    input  logic [$clog2(MEM_WORDS)-1:0]   init_addr,
    input  logic [DATA_WIDTH-1:0]          init_data,
    output logic [$clog2(RESP_DEPTH+1)-1:0] outstanding,
    output logic                           busy,
    output logic                           err_oor
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int QW = $clog2(RESP_DEPTH);
    localparam int OW = $clog2(RESP_DEPTH + 1);
    localparam logic [OW-1:0] CREDITS = OW'(RESP_DEPTH);

    logic [DATA_WIDTH-1:0] sram [MEM_WORDS];

    logic                  ready_en;
    logic [IW-1:0]         idx;
    logic                  oor;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_low;

    logic                  pipe_vld [LATENCY];
    logic [DATA_WIDTH-1:0] pipe_dat [LATENCY];

    logic [DATA_WIDTH-1:0] q_dat [RESP_DEPTH];
    logic [QW-1:0]         wr_ptr;
    logic [QW-1:0]         rd_ptr;
    logic [QW:0]           q_cnt;
    logic                  push;
    logic                  pop;

    // Byte address: low two bits are ignored, upper bits beyond the array
    // flag an out-of-range access.
    assign idx        = mem.mem_req_addr[IW+1:2];
    assign oor        = |mem.mem_req_addr[ADDR_WIDTH-1:IW+2];
    assign unused_low = ^mem.mem_req_addr[1:0];

    // Writes share the credit gate so ready is one signal for both kinds.
    assign mem.mem_req_ready = ready_en && !init_we && (outstanding < CREDITS);
    assign accept  = mem.mem_req_valid && mem.mem_req_ready;
    assign rd_acc  = accept && !mem.mem_req_write;
    assign wr_acc  = accept && mem.mem_req_write;
    assign rd_word = oor ? '0 : sram[idx];

    assign push = pipe_vld[LATENCY-1];
    assign pop  = mem.mem_resp_valid && mem.mem_resp_ready;

    assign mem.mem_resp_valid = (q_cnt != '0);
    assign mem.mem_resp_data  = mem.mem_resp_valid ? q_dat[rd_ptr] : '0;
    assign busy               = (outstanding != '0);

    // SRAM array: backdoor and request port never write in the same cycle.
    always_ff @(posedge clk) begin
        if (init_we) begin
            sram[init_addr] <= init_data;
        end else if (wr_acc && !oor) begin
            sram[idx] <= mem.mem_req_data;
        end
    end

    // Hold ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Fixed-latency delay line carrying data sampled at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            pipe_dat[0] <= rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Response queue storage; credits guarantee a free slot on every push.
    always_ff @(posedge clk) begin
        if (push) begin
            q_dat[wr_ptr] <= pipe_dat[LATENCY-1];
        end
    end

    // Response queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + QW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QW'(1);
            end
            unique case ({push, pop})
                2'b10:   q_cnt <= q_cnt + (QW+1)'(1);
                2'b01:   q_cnt <= q_cnt - (QW+1)'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Credit counter: reads in the delay line plus reads in the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            unique case ({rd_acc, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // One-cycle error pulse following an accepted out-of-range request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oor <= 1'b0;
        end else begin
            err_oor <= accept && oor;
        end
    end
endmodule

// File: tb/tb_warp_mem_responder.sv
// Self-checking bench for warp_mem_responder: directed scenarios followed
// by randomized traffic against an in-order queue reference model.
module tb_warp_mem_responder;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 1024;
    localparam int LAT = 2;
    localparam int RD  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;
    logic [2:0]  outstanding;
    logic        busy;
    logic        err_oor;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [MW];
    logic [31:0] expq [$];

    always #5 clk = ~clk;

    warp_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    warp_mem_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MEM_WORDS (MW),
        .LATENCY   (LAT),
        .RESP_DEPTH(RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (bus),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .outstanding(outstanding),
        .busy       (busy),
        .err_oor    (err_oor)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = w[9:0];
        init_data = d;
        tick();
        init_we   = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp, input logic exp_err);
        int n;
        int lat;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = addr;
        #1;
        n = 0;
        while (!bus.mem_req_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        check({tag, " ready"}, bus.mem_req_ready, 1);
        tick();
        bus.mem_req_valid = 1'b0;
        check({tag, " err"}, err_oor, exp_err);
        tick();
        lat = 1;
        check({tag, " err pulse"}, err_oor, 0);
        while (!bus.mem_resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " data"}, bus.mem_resp_data, exp);
        tick();
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr,
                            input logic [31:0] d, input logic exp_err);
        int n;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = addr;
        bus.mem_req_data  = d;
        #1;
        n = 0;
        while (!bus.mem_req_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        check({tag, " ready"}, bus.mem_req_ready, 1);
        tick();
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        check({tag, " err"}, err_oor, exp_err);
        check({tag, " outstanding"}, outstanding, 0);
        check({tag, " no resp"}, bus.mem_resp_valid, 0);
        tick();
        check({tag, " err pulse"}, err_oor, 0);
    endtask

    initial begin
        int got;
        int acc_k;
        int stale;
        int cnt;
        int n;
        logic exp_err;
        logic acc;
        logic [29:0] widx;
        logic [31:0] got_d [5];
        int got_k [5];

        bus.mem_req_valid  = 1'b0;
        bus.mem_req_addr   = '0;
        bus.mem_req_write  = 1'b0;
        bus.mem_req_data   = '0;
        bus.mem_resp_ready = 1'b1;
        init_we   = 1'b0;
        init_addr = '0;
        init_data = '0;

        #3;
        check("rst req_ready", bus.mem_req_ready, 0);
        check("rst resp_valid", bus.mem_resp_valid, 0);
        check("rst resp_data", bus.mem_resp_data, 0);
        check("rst outstanding", outstanding, 0);
        check("rst busy", busy, 0);
        check("rst err", err_oor, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post-rst ready", bus.mem_req_ready, 1);

        preload(3, 32'h0000_1234);
        preload(4, 32'hCAFE_F00D);
        do_read("rd 0x0c", 32'h0000_000C, 32'h0000_1234, 1'b0);
        do_read("rd 0x11", 32'h0000_0011, 32'hCAFE_F00D, 1'b0);

        do_write("wr 0x20", 32'h0000_0020, 32'hA5A5_A5A5, 1'b0);
        do_read("rd 0x20", 32'h0000_0020, 32'hA5A5_A5A5, 1'b0);

        for (int i = 0; i < 5; i++) begin
            preload(i, 32'(10 + i));
        end
        bus.mem_resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_write = 1'b0;
            bus.mem_req_addr  = 32'(i * 4);
            #1;
            check("fill ready", bus.mem_req_ready, 1);
            tick();
        end
        bus.mem_req_addr = 32'h10;
        #1;
        check("full ready", bus.mem_req_ready, 0);
        check("full outstanding", outstanding, 4);
        check("full busy", busy, 1);
        repeat (3) tick();
        check("hold valid", bus.mem_resp_valid, 1);
        check("hold data", bus.mem_resp_data, 10);
        tick();
        check("hold data stable", bus.mem_resp_data, 10);
        bus.mem_resp_ready = 1'b1;
        got   = 0;
        acc_k = -1;
        for (int k = 0; k < 12 && got < 5; k++) begin
            #1;
            if (bus.mem_req_valid && bus.mem_req_ready) acc_k = k;
            if (bus.mem_resp_valid) begin
                got_d[got] = bus.mem_resp_data;
                got_k[got] = k;
                got++;
            end
            tick();
            if (acc_k >= 0) bus.mem_req_valid = 1'b0;
        end
        bus.mem_req_valid = 1'b0;
        check("drain count", got, 5);
        check("5th accept cycle", acc_k, 1);
        for (int i = 0; i < got; i++) begin
            check("drain data", got_d[i], 32'(10 + i));
            check("drain cycle", got_k[i], i);
        end

        do_read("rd oor", 32'h0000_1000, 32'h0, 1'b1);
        do_write("wr oor", 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        do_read("rd w0", 32'h0000_0000, 32'd10, 1'b0);

        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = 32'h14;
        init_we   = 1'b1;
        init_addr = 10'd5;
        init_data = 32'h55AA_0055;
        #1;
        check("init blocks ready", bus.mem_req_ready, 0);
        tick();
        init_we = 1'b0;
        ref_mem[5] = 32'h55AA_0055;
        #1;
        check("ready after init", bus.mem_req_ready, 1);
        do_read("rd after init", 32'h14, 32'h55AA_0055, 1'b0);

        bus.mem_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_req_valid = 1'b1;
            bus.mem_req_addr  = 32'(i * 4);
            tick();
        end
        bus.mem_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst req_ready", bus.mem_req_ready, 0);
        check("midrst resp_valid", bus.mem_resp_valid, 0);
        check("midrst resp_data", bus.mem_resp_data, 0);
        check("midrst outstanding", outstanding, 0);
        check("midrst busy", busy, 0);
        check("midrst err", err_oor, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.mem_resp_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            tick();
            if (bus.mem_resp_valid) stale++;
        end
        check("no stale resp", stale, 0);
        check("post-rst outstanding", outstanding, 0);
        do_read("rd post-rst", 32'h4, 32'd11, 1'b0);

        for (int w = 0; w < 64; w++) begin
            preload(w, $urandom);
        end
        expq.delete();
        cnt = 0;
        exp_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.mem_resp_ready = ($urandom_range(3) != 0);
            init_we   = ($urandom_range(15) == 0);
            init_addr = 10'($urandom_range(63));
            init_data = $urandom;
            bus.mem_req_valid = $urandom_range(1) != 0;
            bus.mem_req_write = ($urandom_range(3) == 0);
            bus.mem_req_data  = $urandom;
            if ($urandom_range(15) == 0) begin
                bus.mem_req_addr = 32'h1000 | $urandom;
            end else begin
                bus.mem_req_addr = 32'(($urandom_range(63) << 2) | $urandom_range(3));
            end
            #1;
            check("rnd outstanding", outstanding, cnt);
            check("rnd busy", busy, cnt != 0);
            check("rnd err", err_oor, exp_err);
            check("rnd ready", bus.mem_req_ready, !init_we && cnt < RD);
            if (bus.mem_resp_valid) begin
                if (expq.size() == 0) begin
                    check("rnd spurious resp", bus.mem_resp_valid, 0);
                end else begin
                    check("rnd resp data", bus.mem_resp_data, expq[0]);
                end
            end
            exp_err = 1'b0;
            if (bus.mem_resp_valid && bus.mem_resp_ready && expq.size() > 0) begin
                void'(expq.pop_front());
                cnt--;
            end
            acc = bus.mem_req_valid && !init_we && (cnt < RD ||
                  (bus.mem_resp_valid && bus.mem_resp_ready && cnt < RD));
            acc = bus.mem_req_valid && !init_we &&
                  (cnt + ((bus.mem_resp_valid && bus.mem_resp_ready) ? 1 : 0) < RD);
            if (acc) begin
                widx = bus.mem_req_addr[31:2];
                exp_err = (widx >= 30'(MW));
                if (bus.mem_req_write) begin
                    if (!exp_err) ref_mem[widx] = bus.mem_req_data;
                end else begin
                    expq.push_back(exp_err ? 32'h0 : ref_mem[widx]);
                    cnt++;
                end
            end
            if (init_we) ref_mem[init_addr] = init_data;
            tick();
        end

        bus.mem_req_valid  = 1'b0;
        init_we            = 1'b0;
        bus.mem_resp_ready = 1'b1;
        n = 0;
        while (cnt > 0 && n < 50) begin
            #1;
            if (bus.mem_resp_valid && expq.size() > 0) begin
                check("drain rnd data", bus.mem_resp_data, expq[0]);
                void'(expq.pop_front());
                cnt--;
            end
            tick();
            n++;
        end
        #1;
        check("final outstanding", outstanding, 0);
        check("final resp_valid", bus.mem_resp_valid, 0);
        check("final model empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/warp_mem_responder.md
Name: warp_mem_responder

Overview:
- Memory-side responder for the Warp engine's RoCC memory interface; sits opposite the engine's mem_req_*/mem_resp_* ports.
- Holds a word-addressed SRAM model.
- Accepts read/write requests with valid/ready; writes are posted with no response.
- Returns read data in order after a fixed latency through a credit-limited response queue. Includes a backdoor preload port for kernel images and a small status block.

Parameters:
- ADDR_WIDTH, 32, byte address width of mem_req_addr.
- DATA_WIDTH, 32, data word width.
- MEM_WORDS, 1024, SRAM depth in words; power of two, >=4.
- LATENCY, 2, accept-to-response cycles for a read; >=1.
- RESP_DEPTH, 4, maximum outstanding reads and response queue depth; power of two, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req_valid  in  1  request valid
- mem_req_ready  out  1  request accepted when valid&&ready at a clk rising edge
- mem_req_addr  in  ADDR_WIDTH  byte address
- mem_req_write  in  1  1=write, 0=read
- mem_req_data  in  DATA_WIDTH  write data
- mem_resp_valid  out  1  read response valid
- mem_resp_ready  in  1  consumer ready; response retires on valid&&ready
- mem_resp_data  out  DATA_WIDTH  read data
- init_we  in  1  backdoor write strobe
- init_addr  in  $clog2(MEM_WORDS)  backdoor word index
- init_data  in  DATA_WIDTH  backdoor write data
- outstanding  out  $clog2(RESP_DEPTH+1)  reads accepted but not yet retired
- busy  out  1  outstanding!=0
- err_oor  out  1  one-cycle pulse on an accepted out-of-range request

Behaviour:
- Reset, asynchronous on rst_n low:
  - mem_req_ready=0, mem_resp_valid=0, mem_resp_data=0, outstanding=0, busy=0, err_oor=0.
  - Delay line and queue are emptied; any in-flight reads are discarded.
  - SRAM contents are not reset.
  - mem_req_ready may rise from the first clk edge after rst_n deasserts.
- Addressing:
  - Word index = mem_req_addr >> 2. Bits [1:0] are ignored (aligned down, no error).
  - Index >= MEM_WORDS is out of range: a write is dropped, a read returns 0, and err_oor pulses the cycle after accept.
  - An out-of-range read still consumes a credit and returns a response.
- mem_req_ready = !init_we && (outstanding < RESP_DEPTH). Writes are also gated by credits, so ready is a single signal.
- Write accept: the SRAM is updated at the accept edge. A read accepted in any later cycle observes the new value.
- Read accept:
  - SRAM is sampled at the accept edge.
  - The read enters a LATENCY-stage delay line, then the in-order response queue.
  - outstanding increments at the accept edge.
- Response:
  - With an empty queue and mem_resp_ready=1, mem_resp_valid is asserted exactly LATENCY cycles after the accept edge; mem_resp_data is valid in that same cycle.
  - Back-to-back reads produce back-to-back responses, one per cycle, at sustained throughput.
  - While mem_resp_valid=1 and mem_resp_ready=0, data is held stable.
  - Responses retire strictly in accept order.
  - outstanding decrements at the retire edge.
- Same-edge read accept and retire: outstanding is unchanged.
- Credit guarantee: the queue never overflows because at most RESP_DEPTH reads are ever in flight. Hitting the full condition drops mem_req_ready. Ready re-rises the cycle after a retire edge.
- Backdoor:
  - init_we writes init_data to init_addr at the edge.
  - mem_req_ready is forced to 0 that cycle, so there is no port conflict.
  - init_we has no effect on in-flight reads, which have already sampled their data.
- Simultaneous events: no read-after-write hazard, because the request port is single-issue.

Test Plan:
- Preload via init: word 3=0x0000_1234, word 4=0xCAFE_F00D. Read addr 0x0C with resp_ready=1 -> mem_resp_valid exactly 2 cycles after accept, data 0x0000_1234. Read addr 0x11 -> 0xCAFE_F00D (low bits ignored).
- Write addr 0x20 data 0xA5A5_A5A5, then read 0x20 the next cycle -> response 0xA5A5_A5A5. No response is generated for the write, and outstanding stays 0 after the write.
- Hold resp_ready=0 and issue 5 reads to words 0..4 (preloaded 10..14) -> 4 accepted, mem_req_ready=0 with outstanding=4 and busy=1. Release resp_ready -> responses 10,11,12,13 on consecutive cycles. The 5th read is accepted after the first retire and returns 14.
- Read addr 0x1000 (word 1024, MEM_WORDS=1024) -> err_oor pulses one cycle after accept and the response data is 0. Write to 0x1000 -> err_oor pulses and SRAM is unchanged (read word 0 still returns its preload).
- With init_we=1 and mem_req_valid=1 in the same cycle -> mem_req_ready=0, the backdoor write lands, and the request is accepted on the next cycle.
- Issue 3 reads, then assert rst_n=0 mid-flight -> all outputs take their reset values immediately. After release, no stale responses appear, outstanding=0, and a new read returns correct data with latency 2.
